// File: rtl/serial_receiver.sv
// rtl/serial_receiver.sv - 8N1 serial receiver with oversampling baud timer
module serial_receiver #(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic       Clk,
    input  logic       Rst_n,
    input  logic       Rx,
    output logic [7:0] Packet,
    output logic       Receive_flag,
    output logic       Frame_error,
    output logic       Busy
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        BRK
    } state_t;

    state_t          state_q;
    logic            rx_meta_q;
    logic            rx_s_q;
    logic [CW-1:0]   cnt_q;
    logic [2:0]      idx_q;
    logic [7:0]      shift_q;
    logic [7:0]      packet_q;
    logic            rf_q;
    logic            fe_q;

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state_q   <= IDLE;
            rx_meta_q <= 1'b1;
            rx_s_q    <= 1'b1;
            cnt_q     <= '0;
            idx_q     <= '0;
            shift_q   <= '0;
            packet_q  <= '0;
            rf_q      <= 1'b0;
            fe_q      <= 1'b0;
        end else begin
            rx_meta_q <= Rx;
            rx_s_q    <= rx_meta_q;
            rf_q      <= 1'b0;
            fe_q      <= 1'b0;
            case (state_q)
                IDLE: begin
                    cnt_q <= '0;
                    if (!rx_s_q) begin
                        state_q <= START;
                    end
                end
                // Mid-start-bit check: a line that is high again was only a glitch.
                START: begin
                    if (cnt_q == HALF_LAST) begin
                        cnt_q <= '0;
                        if (!rx_s_q) begin
                            state_q <= DATA;
                            idx_q   <= '0;
                        end else begin
                            state_q <= IDLE;
                        end
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                DATA: begin
                    if (cnt_q == BIT_LAST) begin
                        cnt_q          <= '0;
                        shift_q[idx_q] <= rx_s_q;
                        if (idx_q == 3'd7) begin
                            state_q <= STOP;
                        end else begin
                            idx_q <= idx_q + 3'd1;
                        end
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                STOP: begin
                    if (cnt_q == BIT_LAST) begin
                        cnt_q <= '0;
                        if (rx_s_q) begin
                            packet_q <= shift_q;
                            rf_q     <= 1'b1;
                            state_q  <= IDLE;
                        end else begin
                            fe_q    <= 1'b1;
                            state_q <= BRK;
                        end
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                // Held-low line after a bad stop bit must not look like new start bits.
                BRK: begin
                    cnt_q <= '0;
                    if (rx_s_q) begin
                        state_q <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    cnt_q   <= '0;
                end
            endcase
        end
    end

    assign Packet       = packet_q;
    assign Receive_flag = rf_q;
    assign Frame_error  = fe_q;
    assign Busy         = (state_q != IDLE);

endmodule

// File: tb/tb_serial_receiver.sv
// tb/tb_serial_receiver.sv - scoreboard bench for serial_receiver at N=16 and N=4
module tb_serial_receiver;

    typedef struct {
        logic        err;
        logic [7:0]  data;
        int          cyc;
    } ev_t;

    logic       Clk = 1'b0;
    logic       Rst_n = 1'b0;
    logic       rx16 = 1'b1;
    logic       rx4 = 1'b1;
    logic [7:0] pk16, pk4;
    logic       rf16, fe16, busy16, rf4, fe4, busy4;

    int   cyc = 0;
    int   n_pass = 0;
    int   n_total = 0;
    ev_t  q16[$];
    ev_t  q4[$];
    logic [7:0] last_good[2];

    serial_receiver #(.CLKS_PER_BIT(16)) dut16 (
        .Clk(Clk), .Rst_n(Rst_n), .Rx(rx16), .Packet(pk16),
        .Receive_flag(rf16), .Frame_error(fe16), .Busy(busy16)
    );

    serial_receiver #(.CLKS_PER_BIT(4)) dut4 (
        .Clk(Clk), .Rst_n(Rst_n), .Rx(rx4), .Packet(pk4),
        .Receive_flag(rf4), .Frame_error(fe4), .Busy(busy4)
    );

    always #5 Clk = ~Clk;
    always @(posedge Clk) cyc = cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        n_total = n_total + 1;
        if (act == exp) n_pass = n_pass + 1;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    endtask

    task automatic monitor(input string tag, input logic rf, input logic fe, input logic [7:0] pk, inout ev_t q[$]);
        ev_t e;
        if (rf && fe) chk({tag, " strobe exclusivity"}, 1, 0);
        if (rf || fe) begin
            if (q.size() == 0) begin
                chk({tag, " unexpected strobe"}, {30'd0, fe, rf}, 0);
            end else begin
                e = q.pop_front();
                chk({tag, " frame_error kind"}, int'(fe), int'(e.err));
                chk({tag, " packet"}, int'(pk), int'(e.data));
                chk({tag, " strobe cycle"}, cyc, e.cyc);
            end
        end
    endtask

    always @(negedge Clk) begin
        monitor("n16", rf16, fe16, pk16, q16);
        monitor("n4", rf4, fe4, pk4, q4);
    end

    task automatic set_rx(input int sel, input logic v);
        if (sel != 0) rx4 = v;
        else rx16 = v;
    endtask

    task automatic wait_cyc(input int k);
        repeat (k) @(posedge Clk);
        #1;
    endtask

    // Called 1 time unit after a rising edge; the frame occupies exactly 10*N cycles.
    task automatic send_frame(input int sel, input logic [7:0] d, input logic stop);
        int n;
        ev_t e;
        n = (sel != 0) ? 4 : 16;
        e.err  = !stop;
        e.data = stop ? d : last_good[sel];
        e.cyc  = cyc + 3 + n / 2 + 9 * n;
        if (stop) last_good[sel] = d;
        if (sel != 0) q4.push_back(e);
        else q16.push_back(e);
        set_rx(sel, 1'b0);
        wait_cyc(n);
        for (int i = 0; i < 8; i++) begin
            set_rx(sel, d[i]);
            wait_cyc(n);
        end
        set_rx(sel, stop);
        wait_cyc(n);
    endtask

    int c0;

    initial begin
        last_good[0] = 8'h00;
        last_good[1] = 8'h00;
        wait_cyc(3);
        chk("reset packet", int'(pk16), 8'h00);
        chk("reset receive_flag", int'(rf16), 0);
        chk("reset frame_error", int'(fe16), 0);
        chk("reset busy", int'(busy16), 0);
        Rst_n = 1'b1;
        wait_cyc(5);

        c0 = cyc;
        fork
            send_frame(0, 8'h03, 1'b1);
            begin
                @(negedge Clk);
                while (cyc < c0 + 2) @(negedge Clk);
                chk("busy before D", int'(busy16), 0);
                @(negedge Clk);
                chk("busy at D", int'(busy16), 1);
                while (cyc < c0 + 154) @(negedge Clk);
                chk("busy before stop sample", int'(busy16), 1);
                @(negedge Clk);
                chk("busy after stop sample", int'(busy16), 0);
            end
        join
        set_rx(0, 1'b1);
        wait_cyc(20);

        send_frame(0, 8'h03, 1'b1);
        send_frame(0, 8'hA5, 1'b1);
        send_frame(0, 8'h3C, 1'b1);
        send_frame(0, 8'h0F, 1'b1);
        send_frame(0, 8'h01, 1'b1);
        wait_cyc(20);
        chk("packet burst drained", q16.size(), 0);

        set_rx(0, 1'b0);
        wait_cyc(5);
        set_rx(0, 1'b1);
        wait_cyc(20);
        chk("glitch busy back to idle", int'(busy16), 0);

        send_frame(0, 8'h5A, 1'b1);
        send_frame(0, 8'hFF, 1'b0);
        wait_cyc(5);
        chk("busy in break", int'(busy16), 1);
        wait_cyc(40 * 16 - 5);
        chk("packet held after frame error", int'(pk16), 8'h5A);
        set_rx(0, 1'b1);
        wait_cyc(10);
        chk("break left on high line", int'(busy16), 0);
        send_frame(0, 8'h11, 1'b1);
        wait_cyc(10);

        set_rx(0, 1'b0);
        wait_cyc(16);
        for (int i = 0; i < 4; i++) begin
            set_rx(0, (8'hC3 >> i) & 8'h01 ? 1'b1 : 1'b0);
            wait_cyc(16);
        end
        set_rx(0, 1'b0);
        wait_cyc(8);
        Rst_n = 1'b0;
        #1;
        chk("mid-frame reset packet", int'(pk16), 8'h00);
        chk("mid-frame reset busy", int'(busy16), 0);
        chk("mid-frame reset receive_flag", int'(rf16), 0);
        chk("mid-frame reset frame_error", int'(fe16), 0);
        set_rx(0, 1'b1);
        last_good[0] = 8'h00;
        last_good[1] = 8'h00;
        wait_cyc(4);
        Rst_n = 1'b1;
        wait_cyc(20);
        chk("idle after reset release", int'(busy16), 0);
        send_frame(0, 8'h7E, 1'b1);
        wait_cyc(10);
        chk("packet after reset recovery", int'(pk16), 8'h7E);

        send_frame(1, 8'h80, 1'b1);
        send_frame(1, 8'h01, 1'b1);
        wait_cyc(20);
        chk("n4 final packet", int'(pk4), 8'h01);

        chk("n16 queue empty", q16.size(), 0);
        chk("n4 queue empty", q4.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/serial_receiver.md
# serial_receiver

Asynchronous serial (UART-style, 8N1) receiver that sits directly upstream of the packet file-logging stage. It oversamples the single-bit line `Rx` with a clock-count baud timer, deserializes LSB-first bytes, and presents each good byte on `Packet` with a one-cycle `Receive_flag` strobe. It never interprets the byte stream, so the length byte, the data bytes and the parity byte all pass through identically. Stop-bit violations are reported on `Frame_error` and never reach the consumer.

## Interface
- `CLKS_PER_BIT`, 16: clock cycles per serial bit (N). Legal values are ≥ 4. Half-bit H = N/2 (integer division).
- `Clk`  in  1: rising-edge clock.
- `Rst_n`  in  1: asynchronous, active-low reset. One clock, no other clock domains.
- `Rx`  in  1: serial line, idle high, asynchronous to `Clk`.
- `Packet`  out  8: last correctly received byte. Held until the next good byte.
- `Receive_flag`  out  1: one-cycle strobe. `Packet` is valid and new while it is high.
- `Frame_error`  out  1: one-cycle strobe when the stop bit is sampled low.
- `Busy`  out  1: high in every state except IDLE.

## Operation
- **Synchronizer.** `Rx` passes through a 2-flop synchronizer, giving `rx_s`. Both flops reset to 1.
- **Baud counter.** Width is clog2(N). It is cleared on every state entry and after every sample.
- **IDLE.** `Busy`=0. On the edge where `rx_s`=0, go to START.
- **START.** Count to H−1, then sample `rx_s`.
  - Sample 0: go to DATA with bit index 0.
  - Sample 1 (glitch): return to IDLE with no strobe.
- **DATA.** Every N cycles sample `rx_s` into shift register bit [index], LSB first. After index 7 is sampled, go to STOP.
- **STOP.** After N cycles, sample `rx_s`.
  - Sample 1: load `Packet` from the shift register, pulse `Receive_flag`, go to IDLE.
  - Sample 0: pulse `Frame_error`, leave `Packet` unchanged, go to BREAK.
- **BREAK.** Wait until `rx_s`=1, then go to IDLE. This stops a held-low line from re-triggering.
- **Strobe exclusivity.** `Receive_flag` and `Frame_error` are never high together. Each is high for exactly one cycle per frame.
- **Reset.**
  - Reset values: `Packet`=8'h00, `Receive_flag`=0, `Frame_error`=0, `Busy`=0. FSM=IDLE, counter=0, shift register=0, bit index=0.
  - Reset asserted mid-frame aborts the frame with no strobe. After release, the receiver waits for a new falling edge in IDLE.

## Timing
- **Detection edge D.** If `Rx` goes low before clock edge E, `rx_s` is 0 after E+1, and the FSM leaves IDLE at edge D = E+2.
- **Sample edges.**
  - Start bit: D+H.
  - Data bit k (k = 0..7): D+H+(k+1)·N.
  - Stop bit: D+H+9·N.
- **Strobes.** `Receive_flag` or `Frame_error` is high in the cycle after the stop-sample edge. `Packet` takes its new value on that same edge.
- **Back-to-back frames.** IDLE is re-entered on the stop-sample edge. A start bit that begins immediately after the stop bit is caught with no lost frame, which gives at least H cycles of re-arm margin.
- **Glitch rejection.** A low pulse on `rx_s` shorter than H cycles produces no strobe.
- **Throughput.** One byte per 10·N cycles at most.

## Test plan
- **Single byte.** N=16, send 8'h03 → `Packet`=8'h03 and `Receive_flag` high for exactly one cycle, in the cycle after edge D+8+144. `Busy` is high from D to that edge.
- **Full packet.** Send 8'h03, 8'hA5, 8'h3C, 8'h0F, 8'h01 back-to-back with zero idle between frames → 5 strobes carrying those values in order, with none dropped.
- **Glitch.** Drive `Rx` low for 5 cycles, N=16 → no `Receive_flag`, no `Frame_error`, FSM returns to IDLE.
- **Framing error.** Send a good 8'h5A, then a frame with data 8'hFF and the stop bit low, then `Rx` held low for 40·N cycles, then high.
  - `Frame_error` pulses once and `Packet` stays 8'h5A.
  - No further strobes occur while `Rx` is held low.
  - A following 8'h11 frame is received correctly.
- **Reset mid-frame.** Assert `Rst_n`=0 at data bit 4 of 8'hC3 → all outputs reset immediately and no strobe fires. The next frame, 8'h7E, is received with `Packet`=8'h7E.
- **Parameter corner.** With N=4 (H=2), send 8'h80 and 8'h01 → both received correctly with exact sample edges per the Timing section.
